// File: rtl/instr_aligner.sv
// Instruction aligner for a mixed 16/32-bit instruction stream.
// Splits 32-bit fetch words into aligned instructions. A 16-bit hold register
// carries a halfword across fetch words. Issue is one cycle after the input is consumed.
module instr_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] fetch_word,
  input  logic        fetch_valid,
  input  logic        stall_in,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] instr_pc,
  output logic        is_compressed,
  output logic        f1f1,
  output logic        f1f2,
  output logic        hf,
  output logic        fh,
  output logic        hh,
  output logic        stall_compressed
);

  typedef enum logic [1:0] {
    ST_ALIGNED   = 2'd0,
    ST_PEND_FULL = 2'd1,
    ST_PEND_COMP = 2'd2
  } state_t;

  state_t      state_r;
  logic [15:0] hold_r;
  logic        skip_low_r;
  logic [31:0] next_pc_r;

  logic [15:0] lo_s;
  logic [15:0] hi_s;

  // A halfword starts a compressed instruction unless its two low bits are both set.
  function automatic logic is_comp(input logic [15:0] half);
    return (half[1:0] != 2'b11);
  endfunction

  assign lo_s = fetch_word[15:0];
  assign hi_s = fetch_word[31:16];

  // Fetch must re-present its word while the held compressed halfword drains.
  assign stall_compressed = (state_r == ST_PEND_COMP);

  // Alignment FSM with registered issue outputs; flush beats stall_in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_ALIGNED;
      hold_r        <= 16'h0000;
      skip_low_r    <= RESET_PC[1];
      next_pc_r     <= RESET_PC;
      instr         <= 32'h0000_0013;
      instr_pc      <= RESET_PC;
      instr_valid   <= 1'b0;
      is_compressed <= 1'b0;
      f1f1          <= 1'b0;
      f1f2          <= 1'b0;
      hf            <= 1'b0;
      fh            <= 1'b0;
      hh            <= 1'b0;
    end else if (flush) begin
      state_r       <= ST_ALIGNED;
      hold_r        <= 16'h0000;
      skip_low_r    <= flush_pc[1];
      next_pc_r     <= flush_pc;
      instr_valid   <= 1'b0;
      is_compressed <= 1'b0;
      f1f1          <= 1'b0;
      f1f2          <= 1'b0;
      hf            <= 1'b0;
      fh            <= 1'b0;
      hh            <= 1'b0;
    end else if (!stall_in) begin
      // Default: nothing issued; branches below override.
      instr_valid <= 1'b0;
      f1f1        <= 1'b0;
      f1f2        <= 1'b0;
      hf          <= 1'b0;
      fh          <= 1'b0;
      hh          <= 1'b0;
      case (state_r)
        ST_PEND_COMP: begin
          // Drain the held compressed halfword; hh/fh from the entry stays up.
          instr         <= {16'h0000, hold_r};
          instr_valid   <= 1'b1;
          instr_pc      <= next_pc_r;
          is_compressed <= 1'b1;
          hh            <= hh;
          fh            <= fh;
          next_pc_r     <= next_pc_r + 32'd2;
          state_r       <= ST_ALIGNED;
        end
        ST_PEND_FULL: begin
          if (fetch_valid) begin
            instr         <= {lo_s, hold_r};
            instr_valid   <= 1'b1;
            instr_pc      <= next_pc_r;
            is_compressed <= 1'b0;
            next_pc_r     <= next_pc_r + 32'd4;
            hold_r        <= hi_s;
            if (is_comp(hi_s)) begin
              fh      <= 1'b1;
              state_r <= ST_PEND_COMP;
            end else begin
              f1f2    <= 1'b1;
              state_r <= ST_PEND_FULL;
            end
          end else begin
            state_r <= ST_PEND_FULL;
          end
        end
        ST_ALIGNED: begin
          if (!fetch_valid) begin
            state_r <= ST_ALIGNED;
          end else if (skip_low_r) begin
            // Redirect landed on the upper halfword: the low half is discarded.
            skip_low_r <= 1'b0;
            if (is_comp(hi_s)) begin
              instr         <= {16'h0000, hi_s};
              instr_valid   <= 1'b1;
              instr_pc      <= next_pc_r;
              is_compressed <= 1'b1;
              hf            <= 1'b1;
              next_pc_r     <= next_pc_r + 32'd2;
              state_r       <= ST_ALIGNED;
            end else begin
              hold_r  <= hi_s;
              state_r <= ST_PEND_FULL;
            end
          end else if (!is_comp(lo_s)) begin
            instr         <= fetch_word;
            instr_valid   <= 1'b1;
            instr_pc      <= next_pc_r;
            is_compressed <= 1'b0;
            f1f1          <= 1'b1;
            next_pc_r     <= next_pc_r + 32'd4;
            state_r       <= ST_ALIGNED;
          end else begin
            instr         <= {16'h0000, lo_s};
            instr_valid   <= 1'b1;
            instr_pc      <= next_pc_r;
            is_compressed <= 1'b1;
            next_pc_r     <= next_pc_r + 32'd2;
            hold_r        <= hi_s;
            if (is_comp(hi_s)) begin
              hh      <= 1'b1;
              state_r <= ST_PEND_COMP;
            end else begin
              hf      <= 1'b1;
              state_r <= ST_PEND_FULL;
            end
          end
        end
        default: begin
          state_r <= ST_ALIGNED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_aligner.sv
// Directed testbench for instr_aligner with hand-computed expectations.
module tb_instr_aligner;

  logic        clk;
  logic        reset_n;
  logic [31:0] fetch_word;
  logic        fetch_valid;
  logic        stall_in;
  logic        flush;
  logic [31:0] flush_pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic        is_compressed;
  logic        f1f1, f1f2, hf, fh, hh;
  logic        stall_compressed;

  int n_checks = 0;
  int n_pass   = 0;

  // Pattern flag encodings {f1f1,f1f2,hf,fh,hh}.
  localparam logic [4:0] P_NONE = 5'b00000;
  localparam logic [4:0] P_F1F1 = 5'b10000;
  localparam logic [4:0] P_F1F2 = 5'b01000;
  localparam logic [4:0] P_HF   = 5'b00100;
  localparam logic [4:0] P_FH   = 5'b00010;
  localparam logic [4:0] P_HH   = 5'b00001;

  instr_aligner #(.RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .fetch_word       (fetch_word),
    .fetch_valid      (fetch_valid),
    .stall_in         (stall_in),
    .flush            (flush),
    .flush_pc         (flush_pc),
    .instr            (instr),
    .instr_valid      (instr_valid),
    .instr_pc         (instr_pc),
    .is_compressed    (is_compressed),
    .f1f1             (f1f1),
    .f1f2             (f1f2),
    .hf               (hf),
    .fh               (fh),
    .hh               (hh),
    .stall_compressed (stall_compressed)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check a valid issue: instruction, pc, compressed flag, pattern and stall_compressed.
  task automatic expect_issue(input string tag, input logic [31:0] e_instr, input logic [31:0] e_pc,
                              input logic e_comp, input logic [4:0] e_pat, input logic e_stc);
    check_eq({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    check_eq({tag, "_instr"}, instr, e_instr);
    check_eq({tag, "_pc"}, instr_pc, e_pc);
    check_eq({tag, "_comp"}, {31'd0, is_compressed}, {31'd0, e_comp});
    check_eq({tag, "_pat"}, {27'd0, f1f1, f1f2, hf, fh, hh}, {27'd0, e_pat});
    check_eq({tag, "_stc"}, {31'd0, stall_compressed}, {31'd0, e_stc});
  endtask

  task automatic expect_idle(input string tag, input logic e_stc);
    check_eq({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    check_eq({tag, "_pat"}, {27'd0, f1f1, f1f2, hf, fh, hh}, 32'd0);
    check_eq({tag, "_stc"}, {31'd0, stall_compressed}, {31'd0, e_stc});
  endtask

  task automatic do_flush(input string tag, input logic [31:0] pc);
    flush = 1'b1; flush_pc = pc; fetch_valid = 1'b0;
    tick();
    flush = 1'b0;
    expect_idle(tag, 1'b0);
  endtask

  task automatic feed(input logic [31:0] w);
    fetch_word = w; fetch_valid = 1'b1;
    tick();
    fetch_valid = 1'b0;
  endtask

  task automatic expect_reset_vals(input string tag);
    check_eq({tag, "_instr"}, instr, 32'h0000_0013);
    check_eq({tag, "_pc"}, instr_pc, 32'h0000_0000);
    check_eq({tag, "_comp"}, {31'd0, is_compressed}, 32'd0);
    expect_idle(tag, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; fetch_word = 32'h0; fetch_valid = 1'b0;
    stall_in = 1'b0; flush = 1'b0; flush_pc = 32'h0;
    #12;
    expect_reset_vals("rst");
    tick();
    reset_n = 1'b1;
    tick();
    expect_idle("idle", 1'b0);

    // Aligned 32-bit instruction.
    feed(32'h0000_0513);
    expect_issue("f1f1", 32'h0000_0513, 32'h0, 1'b0, P_F1F1, 1'b0);

    // Two compressed in one word; second drains while the next word is ignored.
    do_flush("fl0a", 32'h0);
    feed(32'h4501_4501);
    expect_issue("hh0", 32'h0000_4501, 32'h0, 1'b1, P_HH, 1'b1);
    feed(32'hDEAD_BEEF);
    expect_issue("hh1", 32'h0000_4501, 32'h2, 1'b1, P_HH, 1'b0);
    tick();
    expect_idle("nofetch", 1'b0);

    // Compressed then straddling 32-bit, then compressed.
    do_flush("fl0b", 32'h0);
    feed(32'h0513_4501);
    expect_issue("hf", 32'h0000_4501, 32'h0, 1'b1, P_HF, 1'b0);
    feed(32'h4501_0000);
    expect_issue("fh", 32'h0000_0513, 32'h2, 1'b0, P_FH, 1'b1);
    feed(32'h0000_0513);
    expect_issue("fhc", 32'h0000_4501, 32'h6, 1'b1, P_FH, 1'b0);

    // Redirect to a halfword address with a compressed upper half.
    do_flush("fl102", 32'h0000_0102);
    feed(32'h4501_1234);
    expect_issue("skipc", 32'h0000_4501, 32'h102, 1'b1, P_HF, 1'b0);

    // Redirect to a halfword address with a 32-bit upper half: nothing issued yet.
    do_flush("fl202", 32'h0000_0202);
    feed(32'h0513_4501);
    expect_idle("skipf", 1'b0);
    feed(32'h0013_0000);
    expect_issue("f1f2", 32'h0000_0513, 32'h202, 1'b0, P_F1F2, 1'b0);
    tick();
    expect_idle("pfidle", 1'b0);

    // Stall freezes outputs in PEND_FULL; flush then discards the held half.
    do_flush("fl0c", 32'h0);
    feed(32'h0513_4501);
    expect_issue("pf", 32'h0000_4501, 32'h0, 1'b1, P_HF, 1'b0);
    stall_in = 1'b1; fetch_word = 32'h1111_1113; fetch_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_issue("stall", 32'h0000_4501, 32'h0, 1'b1, P_HF, 1'b0);
    end
    flush = 1'b1; flush_pc = 32'h0000_0040;
    tick();
    flush = 1'b0; stall_in = 1'b0; fetch_valid = 1'b0;
    expect_idle("flstall", 1'b0);
    feed(32'h0000_0013);
    expect_issue("postfl", 32'h0000_0013, 32'h40, 1'b0, P_F1F1, 1'b0);

    // PC wraps modulo 2^32.
    do_flush("flwrap", 32'hFFFF_FFFC);
    feed(32'h0000_0513);
    expect_issue("wrap0", 32'h0000_0513, 32'hFFFF_FFFC, 1'b0, P_F1F1, 1'b0);
    feed(32'h0000_0513);
    expect_issue("wrap1", 32'h0000_0513, 32'h0, 1'b0, P_F1F1, 1'b0);

    // Async reset while in PEND_COMP.
    do_flush("fl0d", 32'h0000_0010);
    feed(32'h4501_4501);
    expect_issue("pc_in", 32'h0000_4501, 32'h10, 1'b1, P_HH, 1'b1);
    reset_n = 1'b0;
    #1;
    expect_reset_vals("midrst");
    tick();
    expect_reset_vals("rsthold");
    reset_n = 1'b1;
    tick();
    expect_idle("rstrel", 1'b0);
    feed(32'h0000_0513);
    expect_issue("afterrst", 32'h0000_0513, 32'h0, 1'b0, P_F1F1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
